// File: rtl/pkt_read_sched.sv
// Round-robin scheduler sharing one packet-buffer read controller among egress ports.
// Define PKT_READ_TIMEOUT_EN to enable the WAIT-state watchdog (err_o abort pulse).
module pkt_read_sched #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = 10,
  parameter int BLOCK_BITS  = 128,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] head_addr_i,
  input  logic [NUM_PORTS-1:0]        rdy_i,
  output logic [NUM_PORTS-1:0]        pop_o,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        busy_o,
  output logic                        rc_re_o,
  output logic                        rc_start_o,
  output logic [ADDR_W-1:0]           rc_start_addr_o,
  input  logic [BLOCK_BITS-1:0]       rc_data_i,
  input  logic                        rc_valid_i,
  input  logic                        rc_end_i,
  output logic [BLOCK_BITS-1:0]       eg_data_o,
  output logic [NUM_PORTS-1:0]        eg_valid_o,
  output logic                        eg_end_o,
  output logic                        err_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;  // last granted port; doubles as the owner while busy
  logic [NUM_PORTS-1:0] grant_q, grant_nxt;
  logic [NUM_PORTS-1:0] eligible;
  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     cand;
  logic                 timeout_hit;

  assign eligible = req_i & rdy_i;

  // First eligible port scanning cyclically after the pointer.
  always_comb begin
    // NOTE: combinational outputs get a default before any branch so no path can infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = PTR_W'((int'(rr_ptr) + off) % NUM_PORTS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= PTR_W'(NUM_PORTS - 1);
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      grant_q <= grant_nxt;
    end
  end

`ifdef PKT_READ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts consecutive WAIT cycles without a returned block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != WAIT || rc_valid_i) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == WAIT) && !rc_valid_i && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = grant_q;
    pop_o           = '0;
    rc_re_o         = 1'b0;
    rc_start_o      = 1'b0;
    rc_start_addr_o = '0;
    eg_valid_o      = '0;
    eg_end_o        = 1'b0;
    err_o           = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt  = START;
          rr_ptr_nxt = pick_idx;
          grant_nxt  = NUM_PORTS'(1) << pick_idx;
        end
      end
      START: begin
        rc_re_o         = 1'b1;
        rc_start_o      = 1'b1;
        rc_start_addr_o = head_addr_i[int'(rr_ptr)*ADDR_W +: ADDR_W];
        pop_o[rr_ptr]   = 1'b1;
        state_nxt       = WAIT;
      end
      WAIT: begin
        if (rc_valid_i) begin
          eg_valid_o[rr_ptr] = 1'b1;
          eg_end_o           = rc_end_i;
          if (rc_end_i) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end else if (rdy_i[rr_ptr]) begin
            rc_re_o = 1'b1;  // chained read: controller follows next_idx from the footer
          end else begin
            state_nxt = HOLD;
          end
        end else if (timeout_hit) begin
          err_o     = 1'b1;
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      HOLD: begin
        if (rdy_i[rr_ptr]) begin
          rc_re_o   = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state != IDLE);
  assign eg_data_o = rc_data_i;

endmodule

// File: tb/tb_pkt_read_sched.sv
// Self-checking bench for pkt_read_sched: descriptor-queue and read-controller models plus
// a scoreboard of expected egress blocks.
module tb_pkt_read_sched;

  localparam int NP = 4;
  localparam int AW = 10;
  localparam int BB = 128;
`ifdef PKT_READ_TIMEOUT_EN
  localparam int ERR_WANT = 1;
`else
  localparam int ERR_WANT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_i, rdy_i, pop_o, grant_o, eg_valid_o;
  logic [NP*AW-1:0] head_addr_i;
  logic             busy_o, rc_re_o, rc_start_o, rc_valid_i, rc_end_i, eg_end_o, err_o;
  logic [AW-1:0]    rc_start_addr_o;
  logic [BB-1:0]    rc_data_i, eg_data_o;

  pkt_read_sched #(.NUM_PORTS(NP), .ADDR_W(AW), .BLOCK_BITS(BB), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .head_addr_i(head_addr_i), .rdy_i(rdy_i),
    .pop_o(pop_o), .grant_o(grant_o), .busy_o(busy_o), .rc_re_o(rc_re_o),
    .rc_start_o(rc_start_o), .rc_start_addr_o(rc_start_addr_o), .rc_data_i(rc_data_i),
    .rc_valid_i(rc_valid_i), .rc_end_i(rc_end_i), .eg_data_o(eg_data_o),
    .eg_valid_o(eg_valid_o), .eg_end_o(eg_end_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [NP-1:0] oh; logic [BB-1:0] data; logic last;} exp_t;
  typedef struct packed {logic v; logic last; logic [BB-1:0] data;} blk_t;

  exp_t          exp_q[$];
  int            n_checks = 0, n_fail = 0;
  int            cyc, err_total;
  logic [AW-1:0] nxt_mem[1024];
  logic          end_mem[1024];
  logic [AW-1:0] desc_mem[NP][32];
  int            desc_rd[NP], desc_wr[NP];
  blk_t          s1, s2, new_req;
  logic [AW-1:0] cur_addr;
  logic          mute;
  logic [NP-1:0] pop_or;
  int            start_cyc_q[$], re_cyc_q[$], eg_cyc_q[$], err_cyc_q[$];
  logic [NP-1:0] start_grant_q[$], start_pop_q[$];
  logic [AW-1:0] start_addr_q[$];
  int            want_sc[$], want_re[$], want_eg[$];
  logic [NP-1:0] want_sg[$];
  logic [26:0]   snap_hist[64];
  logic [NP-1:0] grant_hist[64];
  logic          busy_hist[64];

  function automatic logic [BB-1:0] blk_data(input logic [AW-1:0] a);
    return {4{22'h2A5A5, a}};
  endfunction

  function automatic logic [26:0] snap();
    return {busy_o, grant_o, rc_re_o, rc_start_o, rc_start_addr_o, pop_o, eg_valid_o, eg_end_o, err_o};
  endfunction

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NP; i++) begin
      req_i[i] = (desc_rd[i] != desc_wr[i]);
      head_addr_i[i*AW +: AW] = req_i[i] ? desc_mem[i][desc_rd[i] % 32] : '0;
    end
  endtask

  task automatic load(input int port, input logic [AW-1:0] head);
    desc_mem[port][desc_wr[port] % 32] = head;
    desc_wr[port]++;
    drive_reqs();
  endtask

  // Walks the bench memory chain from head and queues the blocks the owner must receive.
  task automatic expect_pkt(input int port, input logic [AW-1:0] head);
    logic [AW-1:0] a;
    a = head;
    for (int n = 0; n < 16; n++) begin
      exp_q.push_back({NP'(1) << port, blk_data(a), end_mem[a]});
      if (end_mem[a]) break;
      a = nxt_mem[a];
    end
  endtask

  // Monitor at the falling edge, then advance the controller model after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (cyc < 64) begin
      snap_hist[cyc]  = snap();
      grant_hist[cyc] = grant_o;
      busy_hist[cyc]  = busy_o;
    end
    pop_or |= pop_o;
    if (err_o) begin
      err_total++;
      err_cyc_q.push_back(cyc);
    end
    if (rc_start_o) begin
      start_cyc_q.push_back(cyc);
      start_grant_q.push_back(grant_o);
      start_pop_q.push_back(pop_o);
      start_addr_q.push_back(rc_start_addr_o);
    end
    for (int i = 0; i < NP; i++)
      if (pop_o[i] && desc_rd[i] != desc_wr[i]) desc_rd[i]++;
    new_req = '0;
    if (rc_re_o) begin
      re_cyc_q.push_back(cyc);
      if (!mute) begin
        cur_addr = rc_start_o ? rc_start_addr_o : nxt_mem[cur_addr];
        new_req  = {1'b1, end_mem[cur_addr], blk_data(cur_addr)};
      end
    end
    if (eg_valid_o != '0) begin
      eg_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("eg_unexpected", eg_valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("eg_port", eg_valid_o, e.oh);
        check("eg_data", eg_data_o, e.data);
        check("eg_end", eg_end_o, e.last);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    s2 = s1;
    s1 = new_req;
    rc_valid_i = s2.v;
    if (s2.v) begin
      rc_data_i = s2.data;
      rc_end_i  = s2.last;
    end
    drive_reqs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mute = 1'b0;
    rdy_i = '1;
    rc_valid_i = 1'b0;
    s1 = '0;
    s2 = '0;
    for (int i = 0; i < NP; i++) desc_rd[i] = desc_wr[i];
    exp_q.delete();
    drive_reqs();
    #2;
    check("rst_outputs", snap(), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    pop_or = '0;
    start_cyc_q.delete(); start_grant_q.delete(); start_pop_q.delete(); start_addr_q.delete();
    re_cyc_q.delete(); eg_cyc_q.delete(); err_cyc_q.delete();
    want_sc.delete(); want_sg.delete(); want_re.delete(); want_eg.delete();
  endtask

  task automatic check_starts(input string tag);
    check({tag, "_nstart"}, start_cyc_q.size(), want_sc.size());
    for (int k = 0; k < want_sc.size(); k++)
      if (k < start_cyc_q.size()) begin
        check({tag, "_start_cyc"}, start_cyc_q[k], want_sc[k]);
        check({tag, "_grant"}, start_grant_q[k], want_sg[k]);
        check({tag, "_pop"}, start_pop_q[k], want_sg[k]);
      end
  endtask

  task automatic check_re(input string tag);
    check({tag, "_nre"}, re_cyc_q.size(), want_re.size());
    for (int k = 0; k < want_re.size(); k++)
      if (k < re_cyc_q.size()) check({tag, "_re_cyc"}, re_cyc_q[k], want_re[k]);
  endtask

  task automatic check_eg(input string tag);
    check({tag, "_neg"}, eg_cyc_q.size(), want_eg.size());
    for (int k = 0; k < want_eg.size(); k++)
      if (k < eg_cyc_q.size()) check({tag, "_eg_cyc"}, eg_cyc_q[k], want_eg[k]);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      nxt_mem[a] = '0;
      end_mem[a] = 1'b1;
    end
    nxt_mem[10'h010] = 10'h011; end_mem[10'h010] = 1'b0;
    nxt_mem[10'h011] = 10'h012; end_mem[10'h011] = 1'b0;
    nxt_mem[10'h020] = 10'h021; end_mem[10'h020] = 1'b0;
    nxt_mem[10'h021] = 10'h022; end_mem[10'h021] = 1'b0;
    nxt_mem[10'h030] = 10'h031; end_mem[10'h030] = 1'b0;
    nxt_mem[10'h031] = 10'h032; end_mem[10'h031] = 1'b0;
    for (int i = 0; i < NP; i++) begin
      desc_rd[i] = 0;
      desc_wr[i] = 0;
    end
    rc_data_i = '0;
    rc_end_i  = 1'b0;
    cur_addr  = '0;
    err_total = 0;
    cyc       = 0;

    // Single 3-block packet on port 2.
    do_reset();
    load(2, 10'h010);
    expect_pkt(2, 10'h010);
    run(12);
    want_sc = '{1};
    want_sg = '{4'b0100};
    want_re = '{1, 3, 5};
    want_eg = '{3, 5, 7};
    check_starts("single");
    check_re("single");
    check_eg("single");
    if (start_addr_q.size() > 0) check("single_start_addr", start_addr_q[0], 10'h010);
    check("single_busy7", busy_hist[7], 1);
    check("single_idle8", busy_hist[8], 0);
    check("single_drain", exp_q.size(), 0);

    // Round robin across all ports with 1-block packets.
    do_reset();
    load(0, 10'h100); load(1, 10'h101); load(2, 10'h102); load(3, 10'h103);
    load(0, 10'h104); load(1, 10'h105);
    expect_pkt(0, 10'h100); expect_pkt(1, 10'h101); expect_pkt(2, 10'h102);
    expect_pkt(3, 10'h103); expect_pkt(0, 10'h104); expect_pkt(1, 10'h105);
    run(28);
    for (int k = 0; k < 6; k++) begin
      want_sc.push_back(1 + 4 * k);
      want_sg.push_back(NP'(1) << (k % 4));
    end
    check_starts("rr");
    check("rr_drain", exp_q.size(), 0);

    // Requesting but not-ready ports are skipped.
    do_reset();
    rdy_i = 4'b1010;
    load(0, 10'h202); load(1, 10'h200); load(2, 10'h203); load(3, 10'h201);
    expect_pkt(1, 10'h200);
    expect_pkt(3, 10'h201);
    run(14);
    want_sc = '{1, 5};
    want_sg = '{4'b0010, 4'b1000};
    check_starts("elig");
    check("elig_pop02", pop_or & 4'b0101, 0);
    check("elig_drain", exp_q.size(), 0);

    // Backpressure: rdy_i[1] low for 5 cycles starting with block 1.
    do_reset();
    load(1, 10'h020);
    expect_pkt(1, 10'h020);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) rdy_i[1] = 1'b0;
      if (k == 8) rdy_i[1] = 1'b1;
      cycle();
    end
    want_re = '{1, 8, 10};
    want_eg = '{3, 10, 12};
    check_re("bp");
    check_eg("bp");
    check("bp_hold_busy", busy_hist[5], 1);
    check("bp_idle13", busy_hist[13], 0);
    check("bp_drain", exp_q.size(), 0);

    // Reset in WAIT of port 3; the stray block that follows must be dropped.
    do_reset();
    load(3, 10'h030);
    for (int k = 0; k < 14; k++) begin
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      if (k == 4) begin
        load(0, 10'h300);
        load(3, 10'h301);
        expect_pkt(0, 10'h300);
        expect_pkt(3, 10'h301);
      end
      cycle();
    end
    check("mid_rst_outputs", snap_hist[2], 0);
    check("mid_rst_stray", snap_hist[3], 0);
    want_sc = '{1, 5, 9};
    want_sg = '{4'b1000, 4'b0001, 4'b1000};
    check_starts("mid_rst");
    check("mid_rst_drain", exp_q.size(), 0);

`ifdef PKT_READ_TIMEOUT_EN
    // Watchdog: port 1 read never returns, port 2 follows after the abort.
    do_reset();
    mute = 1'b1;
    load(1, 10'h040);
    load(2, 10'h302);
    expect_pkt(2, 10'h302);
    for (int k = 0; k < 24; k++) begin
      if (k == 17) mute = 1'b0;
      cycle();
    end
    check("to_nerr", err_cyc_q.size(), 1);
    if (err_cyc_q.size() > 0) check("to_err_cyc", err_cyc_q[0], 16);
    check("to_grant16", grant_hist[16], 4'b0010);
    check("to_grant17", grant_hist[17], 0);
    want_sc = '{1, 18};
    want_sg = '{4'b0010, 4'b0100};
    want_eg = '{20};
    check_starts("to");
    check_eg("to");
    check("to_drain", exp_q.size(), 0);
`endif

    check("err_total", err_total, ERR_WANT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_read_sched.md
Name: pkt_read_sched

Overview:
- Round-robin scheduler that shares the single packet-buffer read controller among NUM_PORTS egress ports.
- Grants one port at a time for a whole packet. It issues the head-block read, then walks the linked-list chain one block at a time until the footer EOP flag is seen.
- Sits between the egress descriptor queues and the memory read controller. Steers returned blocks to the owning egress port.

Parameters:
- NUM_PORTS, 4, number of egress requesters.
- ADDR_W, 10, block index width.
- BLOCK_BITS, 128, block width in bits.
- TIMEOUT_CYC, 15, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_i  in  NUM_PORTS  port i has a packet head pending.
- head_addr_i  in  NUM_PORTS*ADDR_W  head block index per port; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdy_i  in  NUM_PORTS  port i can accept one block arriving up to 2 cycles later.
- pop_o  out  NUM_PORTS  one-cycle pulse: dequeue head descriptor of port i.
- grant_o  out  NUM_PORTS  one-hot current owner; 0 when idle.
- busy_o  out  1  packet transfer in progress.
- rc_re_o  out  1  read enable to read controller.
- rc_start_o  out  1  marks head-block read; controller uses rc_start_addr_o.
- rc_start_addr_o  out  ADDR_W  head address for the granted port.
- rc_data_i  in  BLOCK_BITS  block from read controller.
- rc_valid_i  in  1  block valid; arrives 2 cycles after rc_re_o.
- rc_end_i  in  1  footer EOP of the current block.
- eg_data_o  out  BLOCK_BITS  block to egress; combinational copy of rc_data_i.
- eg_valid_o  out  NUM_PORTS  one-hot block valid to the owner.
- eg_end_o  out  1  last block of packet.
- err_o  out  1  watchdog abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = NUM_PORTS-1 so port 0 has first priority. Reset mid-packet abandons the transfer; the controller chain is never resumed.
- Eligibility: port i is eligible when req_i[i] & rdy_i[i]. Requesting but not-ready ports are skipped.
- States:
  - IDLE: if any port is eligible, pick the first eligible port cyclically after the RR pointer. Register grant, set pointer = granted index, go to START. Otherwise stay.
  - START (1 cycle): rc_re_o=1, rc_start_o=1, rc_start_addr_o=head_addr_i[owner], pop_o[owner]=1. Go to WAIT.
  - WAIT: on rc_valid_i, drive eg_valid_o[owner]=1 and eg_end_o=rc_end_i.
    - If rc_end_i: go to IDLE.
    - Else if rdy_i[owner]: rc_re_o=1, rc_start_o=0 in the same cycle (controller takes next_idx from the footer); stay in WAIT.
    - Else: go to HOLD.
  - HOLD: wait for rdy_i[owner]. Then rc_re_o=1, rc_start_o=0, go to WAIT. The footer stays valid because the controller holds its last block.
- Outside IDLE, req_i and head_addr_i are ignored. At most one read is outstanding at any time.
- Output gating:
  - eg_valid_o and eg_end_o are gated by state==WAIT. A stray rc_valid_i in IDLE/START/HOLD is dropped.
  - rc_start_addr_o is 0 outside START.
- busy_o=1 in START/WAIT/HOLD. grant_o is registered and held from START through the end of the last WAIT.
- Latency: req at cycle 0 (IDLE) gives rc_re_o at cycle 1 and the first eg_valid at cycle 3. Each next block arrives 2 cycles later when rdy is held.
- Back-to-back packets: IDLE is re-entered the cycle after EOP, giving a 1-cycle gap before the next START.
- Single-block packet: EOP on the first block goes straight to IDLE with no further read.

Optional Feature:
- Macro PKT_READ_TIMEOUT_EN.
- Defined: a counter resets on entry to WAIT and increments each WAIT cycle without rc_valid_i. On reaching TIMEOUT_CYC: err_o pulses 1 cycle, grant clears, state goes to IDLE, the RR pointer still advances past the owner, and no eg_valid is emitted for the aborted packet.
- Undefined: no counter; err_o=0; WAIT waits indefinitely.

Test Plan:
- Single packet: req_i=0100, head_addr 0x010, 3-block chain. Expect one pop_o[2] pulse, rc_start_addr_o=0x010 at cycle 1, eg_valid_o=0100 at cycles 3/5/7, eg_end_o at cycle 7, IDLE at cycle 8.
- RR fairness: req_i=rdy_i=1111 held, 1-block packets. Grants go 0,1,2,3,0,1 with one START per 4 cycles.
- Eligibility skip: req_i=1111, rdy_i=1010. Grants go port1 then port3; no pop_o on ports 0/2.
- Backpressure: 3-block packet on port1, rdy_i[1] low for 5 cycles after block 1. No rc_re_o while low; the second read is issued the cycle rdy returns, and blocks 2/3 are delivered intact.
- Reset mid-packet: rst pulsed in WAIT of port 3, then rc_valid_i=1 the next cycle. Expect all outputs 0, nothing forwarded, and the next grant to port 0.
- Timeout (macro on): no rc_valid_i after START. err_o pulses in WAIT cycle 15, grant_o=0, and the next eligible port is granted.
